local_memory_wb_bridge: RTL and testbench

//  Wishbone B4 classic slave that feeds the wb-side request port of the local SRAM interface.

---
 rtl/local_memory_wb_bridge_pkg.sv | 11 +
 rtl/local_memory_wb_bridge_bus_timeout_counter.sv | 22 ++
 rtl/local_memory_wb_bridge.sv | 99 +++++++++
 tb/tb_local_memory_wb_bridge.sv | 123 ++++++++++++
 4 files changed

// File: rtl/local_memory_wb_bridge_pkg.sv
// local_memory_wb_bridge_pkg: shared state encoding and window decode widths for the WB-to-SRAM bridge
package local_memory_wb_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;
  localparam int WIN_W  = 8;
  localparam int MEM_AW = 32 - WIN_W;
endpackage

// File: rtl/local_memory_wb_bridge_bus_timeout_counter.sv
// bus_timeout_counter: counts stalled request cycles and flags the one that reaches the limit
//  clk, rst_n   clock and async active-low reset
//  i_enable     a stalled request cycle is being counted
//  i_clear      return the count to zero (wins over i_enable)
//  o_expired    this enabled cycle is the TIMEOUT_CYCLES-th stalled one
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);
  logic [TIMEOUT_WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  assign o_expired = i_enable && r_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/local_memory_wb_bridge.sv
// local_memory_wb_bridge: Wishbone B4 classic slave driving the wb-side request port of the local SRAM
//  clk, rst_n                 clock and async active-low reset
//  wb_cyc_i/stb_i/we_i        bus cycle, strobe, write
//  wb_sel_i, wb_adr_i, wb_dat_i  byte lanes, byte address, write data
//  wb_ack_o, wb_err_o         one-cycle completion / error pulses
//  wb_dat_o                   last captured read data
//  memAddress/ByteSelect/WriteEnable/DataWrite  request fields held through REQ
//  memEnable                  request valid (REQ only)
//  memDataRead, memBusy       memory read data and stall
module local_memory_wb_bridge
  import local_memory_wb_bridge_pkg::*;
#(
  parameter logic [WIN_W-1:0] BASE_ADDRESS   = 8'h30,
  parameter int               TIMEOUT_CYCLES = 255,
  parameter int               TIMEOUT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [31:0]       wb_dat_o,
  output logic [MEM_AW-1:0] memAddress,
  output logic [3:0]        memByteSelect,
  output logic              memEnable,
  output logic              memWriteEnable,
  output logic [31:0]       memDataWrite,
  input  logic [31:0]       memDataRead,
  input  logic              memBusy
);
  state_t            r_state, w_next;
  logic [MEM_AW-1:0] r_adr;
  logic [3:0]        r_sel;
  logic              r_we;
  logic [31:0]       r_wdat, r_rdat;
  logic              w_req, w_hit, w_latch, w_capture, w_stall, w_expired;
  assign w_req     = wb_cyc_i && wb_stb_i;
  assign w_hit     = wb_adr_i[31:MEM_AW] == BASE_ADDRESS;
  assign w_stall   = r_state == REQ && wb_cyc_i && memBusy;
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (w_stall),
    .i_clear  (r_state != REQ),
    .o_expired(w_expired)
  );
  // Abort (cyc dropped) outranks completion and timeout while in REQ.
  always_comb begin
    w_next    = IDLE;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        w_next  = w_req ? (w_hit ? REQ : ERR) : IDLE;
        w_latch = w_req && w_hit;
      end
      REQ: begin
        w_next    = !wb_cyc_i ? IDLE : !memBusy ? ACK : w_expired ? ERR : REQ;
        w_capture = wb_cyc_i && !memBusy && !r_we;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_adr  <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_wdat <= '0;
      r_rdat <= '0;
    end else begin
      if (w_latch) begin
        r_adr  <= wb_adr_i[MEM_AW-1:0];
        r_sel  <= wb_sel_i;
        r_we   <= wb_we_i;
        r_wdat <= wb_dat_i;
      end
      if (w_capture) r_rdat <= memDataRead;
    end
  assign memEnable      = r_state == REQ;
  assign wb_ack_o       = r_state == ACK;
  assign wb_err_o       = r_state == ERR;
  assign memAddress     = r_adr;
  assign memByteSelect  = r_sel;
  assign memWriteEnable = r_we;
  assign memDataWrite   = r_wdat;
  assign wb_dat_o       = r_rdat;
endmodule

// File: tb/tb_local_memory_wb_bridge.sv
// tb_local_memory_wb_bridge: directed plus randomized transactions checked against a transaction-level model
module tb_local_memory_wb_bridge;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, busy = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_i = '0, mrd = '0;
  logic        ack, err, men, mwe;
  logic [31:0] dat_o, mdw;
  logic [23:0] madr;
  logic [3:0]  msel;
  int          vectors = 0, miscompares = 0;
  logic [31:0] model_rdat = '0;
  always #5 clk = ~clk;
  local_memory_wb_bridge #(.BASE_ADDRESS(8'h30), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(dat_o),
    .memAddress(madr), .memByteSelect(msel), .memEnable(men), .memWriteEnable(mwe),
    .memDataWrite(mdw), .memDataRead(mrd), .memBusy(busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic quiet(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_men"}, 32'(men), 32'd0);
  endtask
  // One transaction from an IDLE cycle: a hit stalls nb REQ cycles, then acks at +2+nb,
  // unless nb reaches TO, in which case err lands at +TO+1. A miss errs at +1.
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int nb, input logic [31:0] rd);
    logic hit;
    logic ok;
    int   fin;
    hit = a[31:24] == 8'h30;
    ok  = hit && nb < TO;
    fin = !hit ? 1 : ok ? 2 + nb : TO + 1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d; busy = 1'b0; mrd = $urandom;
    for (int t = 1; t <= fin; t++) begin
      @(posedge clk); #1;
      check("men", 32'(men), 32'(t < fin && hit));
      check("ack", 32'(ack), 32'(t == fin && ok));
      check("err", 32'(err), 32'(t == fin && !ok));
      if (t < fin) check("dat_hold", dat_o, model_rdat);
      if (t == 1 && hit) begin
        check("madr", 32'(madr), 32'(a[23:0]));
        check("msel", 32'(msel), 32'(s));
        check("mwe", 32'(mwe), 32'(w));
        check("mdw", mdw, d);
      end
      busy = (t - 1) < nb;
      mrd  = busy ? $urandom : rd;
      if (t == fin) begin cyc = 1'b0; stb = 1'b0; busy = 1'b0; end
    end
    if (ok && !w) model_rdat = rd;
    @(posedge clk); #1;
    quiet("idle");
    check("dat_o", dat_o, model_rdat);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    quiet("rst");
    check("rst_dat", dat_o, 32'd0);
    check("rst_madr", 32'(madr), 32'd0);
    check("rst_mdw", mdw, 32'd0);
    check("rst_msel", 32'(msel), 32'd0);
    check("rst_mwe", 32'(mwe), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
    txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1, 32'hCAFE_F00D);
    txn(1'b0, 32'h3100_0000, 4'hF, 32'h0, 0, 32'h1234_5678);
    txn(1'b0, 32'h30AB_CDEF, 4'h3, 32'h0, 9, 32'h5555_AAAA);
    txn(1'b1, 32'h3000_0004, 4'h0, 32'h0BAD_F00D, 3, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF; busy = 1'b1; mrd = $urandom;
    @(posedge clk); #1;
    check("abort_men1", 32'(men), 32'd1);
    @(posedge clk); #1;
    check("abort_men2", 32'(men), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      quiet("abort");
    end
    busy = 1'b0;
    check("abort_dat", dat_o, model_rdat);
    txn(1'b0, 32'h3000_0200, 4'hF, 32'h0, 3, 32'hCAFE_1234);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[31:24] = ($urandom_range(0, 5) != 0) ? 8'h30 : 8'h31 + 8'($urandom_range(0, 200));
      txn(1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(0, 5)), $urandom);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0300; sel = 4'hA; dat_i = 32'h1111_2222; busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_men", 32'(men), 32'd1);
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; busy = 1'b0;
    #1;
    quiet("mid_rst");
    check("mid_rst_dat", dat_o, 32'd0);
    check("mid_rst_madr", 32'(madr), 32'd0);
    check("mid_rst_mdw", mdw, 32'd0);
    model_rdat = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      quiet("post_rst");
    end
    txn(1'b0, 32'h3000_0040, 4'hF, 32'h0, 0, 32'h7777_8888);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
